// File: rtl/acondicionador_botones_if.sv
// Button bundle: raw active-low pads in, conditioned levels and strobes out.
// Ports: btn_n (pads, 0 = pressed), nivel (1 = pressed), pulso (press strobe).
interface acondicionador_botones_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0] btn_n;
    logic [N_CH-1:0] nivel;
    logic [N_CH-1:0] pulso;

    modport master (
        output btn_n,
        input  nivel,
        input  pulso
    );

    modport slave (
        input  btn_n,
        output nivel,
        output pulso
    );
endinterface

// File: rtl/acondicionador_botones.sv
// Push-button conditioner: per channel 2-FF sync, debounce FSM, press pulse
// and optional auto-repeat. Ports: clk, rst (sync, active-high), bus.slave.
module acondicionador_botones #(
    parameter int              N_CH       = 4,
    parameter int              DB_CYCLES  = 4,
    parameter int              REP_DELAY  = 12,
    parameter int              REP_PERIOD = 4,
    parameter logic [N_CH-1:0] REP_MASK   = N_CH'(4'b0011)
) (
    input  logic clk,
    input  logic rst,
    acondicionador_botones_if.slave bus
);

    localparam int DB_W  = $clog2(DB_CYCLES);
    localparam int REP_W = $clog2(REP_DELAY);

    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DB_CYCLES - 1);
    localparam logic [DB_W-1:0]  DB_ONE     = DB_W'(1);
    localparam logic [REP_W-1:0] REP_LAST   = REP_W'(REP_DELAY - 1);
    localparam logic [REP_W-1:0] REP_RELOAD = REP_W'(REP_DELAY - REP_PERIOD);
    localparam logic [REP_W-1:0] REP_ONE    = REP_W'(1);

    typedef enum logic [1:0] {
        SOLTADO,
        CONF_PRES,
        PRESIONADO,
        CONF_SUELTA
    } estado_t;

    logic [N_CH-1:0] sync1_q, sync1_d;
    logic [N_CH-1:0] sync2_q, sync2_d;
    logic [N_CH-1:0] s;

    estado_t          est_q [N_CH];
    estado_t          est_d [N_CH];
    logic [DB_W-1:0]  db_q  [N_CH];
    logic [DB_W-1:0]  db_d  [N_CH];
    logic [REP_W-1:0] rep_q [N_CH];
    logic [REP_W-1:0] rep_d [N_CH];

    logic [N_CH-1:0] nivel_q, nivel_d;
    logic [N_CH-1:0] pulso_q, pulso_d;

    // Pads idle high, so the synchronizer resets to "released".
    assign sync1_d = bus.btn_n;
    assign sync2_d = sync1_q;
    assign s       = ~sync2_q;

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            est_d[i]   = est_q[i];
            db_d[i]    = db_q[i];
            rep_d[i]   = rep_q[i];
            nivel_d[i] = nivel_q[i];
            pulso_d[i] = 1'b0;

            unique case (est_q[i])
                SOLTADO: begin
                    if (s[i]) begin
                        est_d[i] = CONF_PRES;
                        db_d[i]  = DB_ONE;
                    end
                end

                CONF_PRES: begin
                    if (!s[i]) begin
                        est_d[i] = SOLTADO;
                        db_d[i]  = '0;
                    end else if (db_q[i] == DB_LAST) begin
                        est_d[i]   = PRESIONADO;
                        db_d[i]    = '0;
                        rep_d[i]   = '0;
                        nivel_d[i] = 1'b1;
                        pulso_d[i] = 1'b1;
                    end else begin
                        db_d[i] = db_q[i] + DB_ONE;
                    end
                end

                PRESIONADO: begin
                    if (!s[i]) begin
                        est_d[i] = CONF_SUELTA;
                        db_d[i]  = DB_ONE;
                    end else if (REP_MASK[i]) begin
                        // Reload keeps later repeats REP_PERIOD apart
                        // without the counter ever passing REP_LAST.
                        if (rep_q[i] == REP_LAST) begin
                            rep_d[i]   = REP_RELOAD;
                            pulso_d[i] = 1'b1;
                        end else begin
                            rep_d[i] = rep_q[i] + REP_ONE;
                        end
                    end
                end

                CONF_SUELTA: begin
                    if (s[i]) begin
                        // Release bounce: back to held, repeat timing restarts.
                        est_d[i] = PRESIONADO;
                        db_d[i]  = '0;
                        rep_d[i] = '0;
                    end else if (db_q[i] == DB_LAST) begin
                        est_d[i]   = SOLTADO;
                        db_d[i]    = '0;
                        nivel_d[i] = 1'b0;
                    end else begin
                        db_d[i] = db_q[i] + DB_ONE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '1;
            sync2_q <= '1;
            nivel_q <= '0;
            pulso_q <= '0;
            for (int i = 0; i < N_CH; i++) begin
                est_q[i] <= SOLTADO;
                db_q[i]  <= '0;
                rep_q[i] <= '0;
            end
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            nivel_q <= nivel_d;
            pulso_q <= pulso_d;
            for (int i = 0; i < N_CH; i++) begin
                est_q[i] <= est_d[i];
                db_q[i]  <= db_d[i];
                rep_q[i] <= rep_d[i];
            end
        end
    end

    assign bus.nivel = nivel_q;
    assign bus.pulso = pulso_q;

endmodule
